// File: rtl/servgrid_host_bridge.sv
// Byte-stream to Wishbone host bridge: parses 'W'/'R' commands from an rx byte
// stream, runs one single-beat classic Wishbone access, and streams back status/read data.
module servgrid_host_bridge #(
    parameter int timeout_cycles = 1024,
    parameter int tw             = 11
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_wb_proc_adr,
    output logic [31:0] o_wb_proc_dat,
    output logic [3:0]  o_wb_proc_sel,
    output logic        o_wb_proc_we,
    output logic        o_wb_proc_stb,
    input  logic [31:0] i_wb_proc_rdt,
    input  logic        i_wb_proc_ack,
    output logic        o_busy
);

    localparam logic [7:0] op_write = 8'h57;
    localparam logic [7:0] op_read  = 8'h52;
    localparam logic [7:0] rsp_ack  = 8'h06;
    localparam logic [7:0] rsp_nak  = 8'h15;
    localparam logic [7:0] rsp_bad  = 8'h3F;

    localparam logic [tw-1:0] t_last = tw'(timeout_cycles - 1);
    localparam logic [tw-1:0] t_max  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t state, state_next;

    logic [1:0]    byte_cnt;
    logic          is_write;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [31:0]   rdt_q;
    logic [7:0]    rsp_code;
    logic [2:0]    rsp_idx;
    logic [2:0]    rsp_last;
    logic [tw-1:0] t_cnt;

    logic rx_fire;
    logic tx_fire;
    logic timed_out;

    assign rx_fire   = i_rx_valid & o_rx_ready;
    assign tx_fire   = o_tx_valid & i_tx_ready;
    assign timed_out = (t_cnt == t_last);

    assign o_wb_proc_adr = adr_q;
    assign o_wb_proc_dat = dat_q;
    assign o_wb_proc_sel = 4'hF;
    assign o_wb_proc_we  = o_wb_proc_stb & is_write;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        o_rx_ready    = 1'b0;
        o_tx_valid    = 1'b0;
        o_wb_proc_stb = 1'b0;
        o_busy        = 1'b1;
        case (state)
            S_IDLE: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b0;
                if (rx_fire) begin
                    if (i_rx_data == op_write || i_rx_data == op_read) begin
                        state_next = S_ADDR;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                o_rx_ready = 1'b1;
                if (rx_fire && byte_cnt == 2'd3) begin
                    state_next = is_write ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                o_rx_ready = 1'b1;
                if (rx_fire && byte_cnt == 2'd3) begin
                    state_next = S_BUS;
                end
            end
            S_BUS: begin
                o_wb_proc_stb = 1'b1;
                // ack is checked first so a same-cycle ack wins over expiry
                if (i_wb_proc_ack || timed_out) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_tx_valid = 1'b1;
                if (tx_fire && rsp_idx == rsp_last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_data = '0;
        if (o_tx_valid) begin
            case (rsp_idx)
                3'd0:    o_tx_data = rsp_code;
                3'd1:    o_tx_data = rdt_q[7:0];
                3'd2:    o_tx_data = rdt_q[15:8];
                3'd3:    o_tx_data = rdt_q[23:16];
                3'd4:    o_tx_data = rdt_q[31:24];
                default: o_tx_data = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            byte_cnt <= '0;
            is_write <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdt_q    <= '0;
            rsp_code <= '0;
            rsp_idx  <= '0;
            rsp_last <= '0;
            t_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        is_write <= (i_rx_data == op_write);
                        byte_cnt <= '0;
                        rsp_code <= rsp_bad;
                        rsp_last <= '0;
                        rsp_idx  <= '0;
                    end
                end
                S_ADDR: begin
                    t_cnt <= '0;
                    if (rx_fire) begin
                        adr_q    <= {i_rx_data, adr_q[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_DATA: begin
                    t_cnt <= '0;
                    if (rx_fire) begin
                        dat_q    <= {i_rx_data, dat_q[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_BUS: begin
                    if (i_wb_proc_ack) begin
                        rsp_code <= rsp_ack;
                        rsp_last <= is_write ? 3'd0 : 3'd4;
                        rsp_idx  <= '0;
                        if (!is_write) begin
                            rdt_q <= i_wb_proc_rdt;
                        end
                    end else if (timed_out) begin
                        rsp_code <= rsp_nak;
                        rsp_last <= '0;
                        rsp_idx  <= '0;
                    end else if (t_cnt != t_max) begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (tx_fire && rsp_idx != rsp_last) begin
                        rsp_idx <= rsp_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
